// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, coordinate width,
// sync polarity constants and the raw sync/visible decode helper.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int DIV_W   = 4;     // holds 0..15, enough for CLK_DIV up to 16

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_H_VIS      = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VIS      = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SYNC_DELAY = 2;

    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic SYNC_ACT  = 1'b0;
    localparam logic SYNC_IDLE = 1'b1;

    // Bundle carried through the delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic vid;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: SYNC_IDLE, vs: SYNC_IDLE, vid: 1'b0};

    // Raw decode of one coordinate pair; the *_end bounds are exclusive
    function automatic sync_t sync_decode(
        input logic [COORD_W-1:0] h,
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] h_vis,
        input logic [COORD_W-1:0] hs_beg,
        input logic [COORD_W-1:0] hs_end,
        input logic [COORD_W-1:0] v_vis,
        input logic [COORD_W-1:0] vs_beg,
        input logic [COORD_W-1:0] vs_end
    );
        sync_t s;
        s.hs  = ((h >= hs_beg) && (h < hs_end)) ? SYNC_ACT : SYNC_IDLE;
        s.vs  = ((v >= vs_beg) && (v < vs_end)) ? SYNC_ACT : SYNC_IDLE;
        s.vid = (h < h_vis) && (v < v_vis);
        return s;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-tick enabled shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = ^{clk, rst_n, en};
            assign dout     = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            // Shift one stage per enable; stage 0 takes din
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= {DEPTH{RST_VAL}};
                end else if (en) begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, h/v scan counters, registered
// sync/visible decode delayed to match downstream pixel latency.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_VIS      = DEF_H_VIS,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VIS      = DEF_V_VIS,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_tick,
    output logic [COORD_W-1:0] h_count,
    output logic [COORD_W-1:0] v_count,
    output logic               hs,
    output logic               vs,
    output logic               video_on,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_MAX   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_MAX   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic               r_tick;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    sync_t              r_raw;
    sync_t              w_sync;
    logic               r_frame;

    // Divider and counter next-state
    always_comb begin
        w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
        w_h_wrap  = (r_h == H_MAX);
        w_v_wrap  = (r_v == V_MAX);
        w_h_nxt   = w_h_wrap ? '0 : r_h + 1'b1;
        w_v_nxt   = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + 1'b1;
        end
    end

    // Pixel tick: registered so it is high while the divider sits at its max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_tick <= (w_div_nxt == DIV_MAX);
        end
    end

    // Scan counters plus raw decode of the value being loaded, so the decode
    // always describes the current counter value rather than the previous one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h   <= '0;
            r_v   <= '0;
            r_raw <= SYNC_RST;
        end else if (r_tick) begin
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_raw <= sync_decode(w_h_nxt, w_v_nxt, H_VIS_C, HS_BEG, HS_END,
                                 V_VIS_C, VS_BEG, VS_END);
        end
    end

    // Frame start: one clk pulse coincident with the freshly loaded (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= r_tick && w_h_wrap && w_v_wrap;
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (SYNC_RST)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_tick),
        .din   (r_raw),
        .dout  (w_sync)
    );

    assign pix_tick    = r_tick;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign hs          = w_sync.hs;
    assign vs          = w_sync.vs;
    assign video_on    = w_sync.vid;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four configurations checked every clk against an
// arithmetic model (position = ticks since reset mod frame size).
module tb_vga_sync_gen;

    localparam int NI = 4;
    localparam int DIV[NI]   = '{4, 4, 1, 3};
    localparam int DLY[NI]   = '{2, 0, 2, 5};
    localparam int SMALL[NI] = '{1, 1, 0, 1};

    typedef struct {
        int tick, h, v, hs, vs, vid, fs;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       tick [NI];
    logic [9:0] hc   [NI];
    logic [9:0] vc   [NI];
    logic       hs   [NI];
    logic       vs   [NI];
    logic       vid  [NI];
    logic       fs   [NI];

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;

    int fs_cnt, last_wrap, prev_h2, hs_run, prev_hs2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen #(.CLK_DIV(4), .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick[0]), .h_count(hc[0]), .v_count(vc[0]),
        .hs(hs[0]), .vs(vs[0]), .video_on(vid[0]), .frame_start(fs[0]));

    vga_sync_gen #(.CLK_DIV(4), .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick[1]), .h_count(hc[1]), .v_count(vc[1]),
        .hs(hs[1]), .vs(vs[1]), .video_on(vid[1]), .frame_start(fs[1]));

    vga_sync_gen #(.CLK_DIV(1), .SYNC_DELAY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick[2]), .h_count(hc[2]), .v_count(vc[2]),
        .hs(hs[2]), .vs(vs[2]), .video_on(vid[2]), .frame_start(fs[2]));

    vga_sync_gen #(.CLK_DIV(3), .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(5)) u_d (
        .clk(clk), .rst_n(rst_n), .pix_tick(tick[3]), .h_count(hc[3]), .v_count(vc[3]),
        .hs(hs[3]), .vs(vs[3]), .video_on(vid[3]), .frame_start(fs[3]));

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", tag, obs, exp, $time, n);
        end
    endtask

    // Ticks completed by the end of clk n after reset release
    function automatic int kf(int cyc, int div);
        if (cyc <= 0) return 0;
        if (div == 1) return cyc - 1;
        return cyc / div;
    endfunction

    function automatic exp_t model(int cyc, int i);
        exp_t e;
        int hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, tot, k, p, q, hq, vq;
        if (SMALL[i] != 0) begin
            hv = 16;  hf = 4;  hsw = 6;  hb = 4;  vv = 8;   vf = 2;  vsw = 2; vb = 3;
        end else begin
            hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        tot = ht * vt;
        e = '{tick: 0, h: 0, v: 0, hs: 1, vs: 1, vid: 0, fs: 0};
        if (cyc == 0) return e;
        e.tick = (DIV[i] == 1) ? 1 : (((cyc % DIV[i]) == DIV[i] - 1) ? 1 : 0);
        k = kf(cyc, DIV[i]);
        p = k % tot;
        e.h = p % ht;
        e.v = p / ht;
        e.fs = ((k != kf(cyc - 1, DIV[i])) && (p == 0)) ? 1 : 0;
        q = k - DLY[i];
        if (q >= 1) begin
            hq = (q % tot) % ht;
            vq = (q % tot) / ht;
            e.hs  = (hq >= hv + hf && hq < hv + hf + hsw) ? 0 : 1;
            e.vs  = (vq >= vv + vf && vq < vv + vf + vsw) ? 0 : 1;
            e.vid = (hq < hv && vq < vv) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic check_all(input int cyc);
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            e = model(cyc, i);
            chk($sformatf("u%0d pix_tick", i), int'(tick[i]), e.tick);
            chk($sformatf("u%0d h_count", i), int'(hc[i]), e.h);
            chk($sformatf("u%0d v_count", i), int'(vc[i]), e.v);
            chk($sformatf("u%0d hs", i), int'(hs[i]), e.hs);
            chk($sformatf("u%0d vs", i), int'(vs[i]), e.vs);
            chk($sformatf("u%0d video_on", i), int'(vid[i]), e.vid);
            chk($sformatf("u%0d frame_start", i), int'(fs[i]), e.fs);
        end
    endtask

    task automatic clear_aggr();
        fs_cnt = 0; last_wrap = 0; prev_h2 = 0; hs_run = 0; prev_hs2 = 1;
    endtask

    // Advance cycles clks, checking every clk plus line-level properties of u_c
    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            n++;
            #1;
            check_all(n);
            if (fs[0]) fs_cnt++;
            if (hc[2] == 10'd0 && prev_h2 == 799) begin
                if (last_wrap > 0) chk("u2 line period", n - last_wrap, 800);
                last_wrap = n;
            end
            prev_h2 = int'(hc[2]);
            if (prev_hs2 == 1 && hs[2] == 1'b0) chk("u2 hs fall h", int'(hc[2]), 658);
            if (hs[2] == 1'b0) hs_run++;
            if (prev_hs2 == 0 && hs[2] == 1'b1) begin
                chk("u2 hs width", hs_run, 96);
                hs_run = 0;
            end
            prev_hs2 = int'(hs[2]);
        end
    endtask

    initial begin
        int hold;
        rst_n = 1'b0;
        clear_aggr();
        repeat (3) @(posedge clk);
        #1;
        check_all(0);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        run(3600);
        chk("u0 frame count", fs_cnt, kf(n, 4) / 450);
        run($urandom_range(100, 600));

        // Asynchronous reset between clock edges, mid-line
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        check_all(0);
        hold = $urandom_range(2, 9);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_all(0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        clear_aggr();
        run(2000 + $urandom_range(0, 300));
        chk("u0 frame count after reset", fs_cnt, kf(n, 4) / 450);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
